// File: rtl/ultrasonic_ranger.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ultrasonic_ranger
// Single-sensor ultrasonic ranging controller (HC-SR04 class).
// Fires a periodic trigger pulse, synchronises and glitch-filters the echo,
// measures the echo high time in clock cycles and flags cycles that end
// without a usable echo. A near-object indicator follows each new width.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       1 = run measurement cycles; 0 = stop after the current cycle
//   echo_pin     raw asynchronous echo from the sensor
//   near_thresh  near-object threshold in clocks
//   trigger_pin  registered trigger to the sensor
//   pulse_width  last valid echo width in clocks
//   width_valid  one-cycle strobe when pulse_width updates
//   timeout      one-cycle strobe when a cycle ends without a valid echo
//   LED_pin      registered near indicator (pulse_width < near_thresh)
//   busy         high whenever the controller is not idle
// ---------------------------------------------------------------------------
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 270,
    parameter int PERIOD_CYCLES  = 1620000,
    parameter int TIMEOUT_CYCLES = 810000,
    parameter int FILTER_CYCLES  = 16,
    parameter int WIDTH_W        = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               echo_pin,
    input  logic [WIDTH_W-1:0] near_thresh,
    output logic               trigger_pin,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic               width_valid,
    output logic               timeout,
    output logic               LED_pin,
    output logic               busy
);

    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int TRG_W = $clog2(TRIG_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [PER_W-1:0]   PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TRG_W-1:0]   TRG_LAST  = TRG_W'(TRIG_CYCLES - 1);
    localparam logic [FLT_W-1:0]   FLT_LAST  = FLT_W'(FILTER_CYCLES - 1);
    localparam logic [WIDTH_W-1:0] WAIT_LAST = WIDTH_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH_W-1:0] MEAS_MAX  = WIDTH_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIGGER   = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    // Echo conditioning
    logic             sync1_r;
    logic             sync2_r;
    logic             echo_f_r;
    logic             echo_d_r;
    logic [FLT_W-1:0] flt_cnt_r;
    logic             rise_s;
    logic             fall_s;

    // FSM and counters
    state_t             state_r;
    state_t             state_nxt_s;
    logic [TRG_W-1:0]   trig_cnt_r;
    logic [TRG_W-1:0]   trig_cnt_nxt_s;
    logic [WIDTH_W-1:0] cnt_r;          // wait counter in WAIT_RISE, width counter in MEASURE
    logic [WIDTH_W-1:0] cnt_nxt_s;
    logic [PER_W-1:0]   per_cnt_r;
    logic [PER_W-1:0]   per_nxt_s;
    logic [PER_W-1:0]   per_inc_s;
    logic [WIDTH_W-1:0] pw_nxt_s;
    logic               wv_nxt_s;
    logic               to_nxt_s;

    // Two-flop synchroniser followed by a consecutive-sample level filter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            echo_f_r  <= 1'b0;
            echo_d_r  <= 1'b0;
            flt_cnt_r <= FLT_W'(0);
        end else begin
            sync1_r  <= echo_pin;
            sync2_r  <= sync1_r;
            echo_d_r <= echo_f_r;
            if (sync2_r == echo_f_r) begin
                flt_cnt_r <= FLT_W'(0);
            end else if (flt_cnt_r == FLT_LAST) begin
                // FILTER_CYCLES consecutive disagreeing samples: accept the new level
                echo_f_r  <= sync2_r;
                flt_cnt_r <= FLT_W'(0);
            end else begin
                flt_cnt_r <= flt_cnt_r + FLT_W'(1);
            end
        end
    end

    assign rise_s = echo_f_r & ~echo_d_r;
    assign fall_s = ~echo_f_r & echo_d_r;

    // Period counter saturates at its last value so a short period never wraps
    assign per_inc_s = (per_cnt_r < PER_LAST) ? (per_cnt_r + PER_W'(1)) : per_cnt_r;

    // Next-state and next-output logic for the ranging FSM
    always_comb begin
        state_nxt_s    = state_r;
        trig_cnt_nxt_s = trig_cnt_r;
        cnt_nxt_s      = cnt_r;
        per_nxt_s      = per_inc_s;
        pw_nxt_s       = pulse_width;
        wv_nxt_s       = 1'b0;
        to_nxt_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                per_nxt_s      = PER_W'(0);
                trig_cnt_nxt_s = TRG_W'(0);
                cnt_nxt_s      = WIDTH_W'(0);
                if (enable) begin
                    state_nxt_s = S_TRIGGER;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end

            S_TRIGGER: begin
                if (trig_cnt_r == TRG_LAST) begin
                    state_nxt_s    = S_WAIT_RISE;
                    trig_cnt_nxt_s = TRG_W'(0);
                    cnt_nxt_s      = WIDTH_W'(0);
                end else begin
                    trig_cnt_nxt_s = trig_cnt_r + TRG_W'(1);
                end
            end

            S_WAIT_RISE: begin
                // Only a fresh rising edge starts a measurement; a level that
                // was already high on entry produces no rise_s.
                if (rise_s) begin
                    state_nxt_s = S_MEASURE;
                    cnt_nxt_s   = WIDTH_W'(1);
                end else if (cnt_r == WAIT_LAST) begin
                    state_nxt_s = S_HOLDOFF;
                    to_nxt_s    = 1'b1;
                    cnt_nxt_s   = WIDTH_W'(0);
                end else begin
                    cnt_nxt_s = cnt_r + WIDTH_W'(1);
                end
            end

            S_MEASURE: begin
                // A fall on the same cycle the limit is reached still counts as valid
                if (fall_s) begin
                    state_nxt_s = S_HOLDOFF;
                    pw_nxt_s    = cnt_r;
                    wv_nxt_s    = 1'b1;
                    cnt_nxt_s   = WIDTH_W'(0);
                end else if (cnt_r == MEAS_MAX) begin
                    state_nxt_s = S_HOLDOFF;
                    to_nxt_s    = 1'b1;
                    cnt_nxt_s   = WIDTH_W'(0);
                end else begin
                    cnt_nxt_s = cnt_r + WIDTH_W'(1);
                end
            end

            S_HOLDOFF: begin
                if (per_cnt_r >= PER_LAST) begin
                    if (enable) begin
                        state_nxt_s = S_TRIGGER;
                        per_nxt_s   = PER_W'(0);
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_HOLDOFF;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered FSM outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            trig_cnt_r  <= TRG_W'(0);
            cnt_r       <= WIDTH_W'(0);
            per_cnt_r   <= PER_W'(0);
            pulse_width <= WIDTH_W'(0);
            width_valid <= 1'b0;
            timeout     <= 1'b0;
            trigger_pin <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            trig_cnt_r  <= trig_cnt_nxt_s;
            cnt_r       <= cnt_nxt_s;
            per_cnt_r   <= per_nxt_s;
            pulse_width <= pw_nxt_s;
            width_valid <= wv_nxt_s;
            timeout     <= to_nxt_s;
            // Decoded from the next state so the pin lines up with the state register
            trigger_pin <= (state_nxt_s == S_TRIGGER);
            busy        <= (state_nxt_s != S_IDLE);
        end
    end

    // Near indicator follows each new width one cycle later; a timeout clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LED_pin <= 1'b0;
        end else if (width_valid) begin
            LED_pin <= (pulse_width < near_thresh);
        end else if (timeout) begin
            LED_pin <= 1'b0;
        end else begin
            LED_pin <= LED_pin;
        end
    end

endmodule
